// File: rtl/lcd_timing_multiwin_if.sv
// Panel-side bundle of lcd_timing_multiwin: video pins, per-window requests, returned
// pixel data and the per-frame box inputs.
interface lcd_timing_multiwin_if #(
  parameter int unsigned NUM_WIN = 2,
  parameter int unsigned DATA_W  = 24
);
  logic              lcd_hs;
  logic              lcd_vs;
  logic              lcd_en;
  logic [DATA_W-1:0] lcd_rgb;
  logic [NUM_WIN-1:0] lcd_request;
  logic [11:0]       lcd_req_x;
  logic [11:0]       lcd_req_y;
  logic [DATA_W-1:0] lcd_data;
  logic              box_valid;
  logic [11:0]       box_x0;
  logic [11:0]       box_x1;
  logic [11:0]       box_y0;
  logic [11:0]       box_y1;
  logic              frame_start;

  modport master (
    output lcd_hs, lcd_vs, lcd_en, lcd_rgb, lcd_request, lcd_req_x, lcd_req_y, frame_start,
    input  lcd_data, box_valid, box_x0, box_x1, box_y0, box_y1
  );

  modport slave (
    input  lcd_hs, lcd_vs, lcd_en, lcd_rgb, lcd_request, lcd_req_x, lcd_req_y, frame_start,
    output lcd_data, box_valid, box_x0, box_x1, box_y0, box_y1
  );
endinterface

// File: rtl/lcd_timing_multiwin.sv
// LCD timing generator with NUM_WIN side-by-side windows and a frame-shadowed box overlay.
// Optional LCD_BOX_BLINK_EN: 8-bit frame counter blinks the overlay 32 frames on / 32 off.
module lcd_timing_multiwin #(
  parameter int unsigned H_SYNC  = 40,
  parameter int unsigned H_BACK  = 220,
  parameter int unsigned H_DISP  = 1280,
  parameter int unsigned H_FRONT = 110,
  parameter int unsigned V_SYNC  = 5,
  parameter int unsigned V_BACK  = 20,
  parameter int unsigned V_DISP  = 720,
  parameter int unsigned V_FRONT = 5,
  parameter int unsigned H_AHEAD = 5,
  parameter int unsigned NUM_WIN = 2,
  parameter int unsigned WIN_W   = 640,
  parameter int unsigned WIN_Y0  = 120,
  parameter int unsigned WIN_H   = 480,
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned BOX_T   = 2,
  parameter logic [DATA_W-1:0] BOX_COLOR = 24'hFF0000
) (
  input logic clk,
  input logic rst_n,
  lcd_timing_multiwin_if.master bus
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic signed [13:0] TM = 14'(BOX_T - 1);

  logic [11:0] hcnt_q, vcnt_q;
  logic signed [13:0] dx, dy, rx;
  logic de_c;
  logic [NUM_WIN-1:0] req;
  logic [11:0] req_x, req_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (hcnt_q == 12'(H_TOTAL - 1)) begin
      hcnt_q <= '0;
      vcnt_q <= (vcnt_q == 12'(V_TOTAL - 1)) ? '0 : vcnt_q + 12'd1;
    end else begin
      hcnt_q <= hcnt_q + 12'd1;
    end
  end

  // 14-bit signed so coordinates left/above the display and box edges near 4095 never wrap.
  assign dx   = $signed({2'b00, hcnt_q}) - $signed(14'(H_SYNC + H_BACK));
  assign dy   = $signed({2'b00, vcnt_q}) - $signed(14'(V_SYNC + V_BACK));
  assign rx   = dx + $signed(14'(H_AHEAD));
  assign de_c = (dx >= 0) && (dx < $signed(14'(H_DISP))) &&
                (dy >= 0) && (dy < $signed(14'(V_DISP)));

  assign bus.frame_start = (hcnt_q == '0) && (vcnt_q == '0);

  always_comb begin
    req   = '0;
    req_x = '0;
    req_y = '0;
    if ((dy >= $signed(14'(WIN_Y0))) && (dy < $signed(14'(WIN_Y0 + WIN_H)))) begin
      for (int k = 0; k < NUM_WIN; k++) begin
        if ((rx >= $signed(14'(k * WIN_W))) && (rx < $signed(14'((k + 1) * WIN_W)))) begin
          req[k] = 1'b1;
          req_x  = 12'(rx - $signed(14'(k * WIN_W)));
          req_y  = 12'(dy - $signed(14'(WIN_Y0)));
        end
      end
    end
  end

  assign bus.lcd_request = req;
  assign bus.lcd_req_x   = req_x;
  assign bus.lcd_req_y   = req_y;

  logic blink_off;
`ifdef LCD_BOX_BLINK_EN
  logic [7:0] frame_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (bus.frame_start) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end
  // Pre-increment value decides the upcoming frame, so frames 0..31 are drawn.
  assign blink_off = frame_cnt_q[5];
`else
  assign blink_off = 1'b0;
`endif

  logic        box_on_q;
  logic [11:0] x0_q, x1_q, y0_q, y1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_on_q <= 1'b0;
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
    end else if (bus.frame_start) begin
      box_on_q <= bus.box_valid && (bus.box_x0 <= bus.box_x1) &&
                  (bus.box_y0 <= bus.box_y1) && !blink_off;
      if (bus.box_valid) begin
        x0_q <= bus.box_x0;
        x1_q <= bus.box_x1;
        y0_q <= bus.box_y0;
        y1_q <= bus.box_y1;
      end
    end
  end

  logic signed [13:0] sx0, sx1, sy0, sy1;
  logic outer, inner, overlay;

  assign sx0 = $signed({2'b00, x0_q});
  assign sx1 = $signed({2'b00, x1_q});
  assign sy0 = $signed({2'b00, y0_q});
  assign sy1 = $signed({2'b00, y1_q});

  assign outer = (dx >= sx0 - TM) && (dx <= sx1 + TM) && (dy >= sy0 - TM) && (dy <= sy1 + TM);
  assign inner = (dx > sx0 + TM) && (dx < sx1 - TM) && (dy > sy0 + TM) && (dy < sy1 - TM);
  assign overlay = box_on_q && outer && !inner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.lcd_hs  <= 1'b0;
      bus.lcd_vs  <= 1'b0;
      bus.lcd_en  <= 1'b0;
      bus.lcd_rgb <= '0;
    end else begin
      bus.lcd_hs  <= (hcnt_q >= 12'(H_SYNC));
      bus.lcd_vs  <= (vcnt_q >= 12'(V_SYNC));
      bus.lcd_en  <= de_c;
      bus.lcd_rgb <= !de_c ? '0 : (overlay ? BOX_COLOR : bus.lcd_data);
    end
  end

endmodule

// File: tb/tb_lcd_timing_multiwin.sv
// Self-checking bench for lcd_timing_multiwin on a shrunken raster, with a delayed reader
// model and an integer reference model of timing, requests and the box overlay.
module tb_lcd_timing_multiwin;

  localparam int HS = 4, HB = 8, HD = 40, HF = 4;
  localparam int VS = 2, VB = 3, VD = 30, VF = 2;
  localparam int AH = 3, NW = 2, WW = 16, Y0 = 5, WH = 20, BT = 2;
  localparam logic [23:0] COLOR = 24'hFF0000;
  localparam int HT = HS + HB + HD + HF;
  localparam int VT = VS + VB + VD + VF;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_timing_multiwin_if #(.NUM_WIN(NW), .DATA_W(24)) bus ();

  lcd_timing_multiwin #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
    .H_AHEAD(AH), .NUM_WIN(NW), .WIN_W(WW), .WIN_Y0(Y0), .WIN_H(WH),
    .DATA_W(24), .BOX_T(BT), .BOX_COLOR(COLOR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reader: returns {window, y, x} of the request exactly AH cycles later, black otherwise.
  logic [1:0]  rd_win;
  logic [23:0] rd_val;
  logic [23:0] pipe [AH];

  always_comb begin
    rd_win = '0;
    for (int k = 0; k < NW; k++) if (bus.lcd_request[k]) rd_win = 2'(k);
    rd_val = (bus.lcd_request != '0) ? {rd_win, bus.lcd_req_y[9:0], bus.lcd_req_x} : '0;
  end

  always @(posedge clk) begin
    pipe[0] <= rd_val;
    for (int i = 1; i < AH; i++) pipe[i] <= pipe[i-1];
  end

  assign bus.lcd_data = pipe[AH-1];

  int tests = 0;
  int fails = 0;

  // Reference model state
  int mh, mv, fcnt;
  bit m_on;
  int mx0, mx1, my0, my1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int dx, input int dy);
    if (dy >= Y0 && dy < Y0 + WH && dx >= 0 && dx < NW * WW)
      return {2'(dx / WW), 10'(dy - Y0), 12'(dx % WW)};
    return '0;
  endfunction

  function automatic bit on_box(input int dx, input int dy);
    int t;
    bit outer, inner;
    t = BT - 1;
    outer = dx >= mx0 - t && dx <= mx1 + t && dy >= my0 - t && dy <= my1 + t;
    inner = dx > mx0 + t && dx < mx1 - t && dy > my0 + t && dy < my1 - t;
    return m_on && outer && !inner;
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; fcnt = 0; m_on = 0;
    mx0 = 0; mx1 = 0; my0 = 0; my1 = 0;
  endtask

  task automatic step();
    int pdx, pdy, cdx, cdy, r;
    bit act, blank;
    logic [23:0] e_rgb;
    logic [NW-1:0] e_req;
    logic [11:0] e_x, e_y;
    @(posedge clk);
    if (mh == 0 && mv == 0) begin
      blank = 1'b0;
`ifdef LCD_BOX_BLINK_EN
      blank = ((fcnt / 32) % 2) == 1;
`endif
      m_on = bus.box_valid && bus.box_x0 <= bus.box_x1 && bus.box_y0 <= bus.box_y1 && !blank;
      if (bus.box_valid) begin
        mx0 = int'(bus.box_x0); mx1 = int'(bus.box_x1);
        my0 = int'(bus.box_y0); my1 = int'(bus.box_y1);
      end
      fcnt++;
    end
    pdx = mh - (HS + HB);
    pdy = mv - (VS + VB);
    act = pdx >= 0 && pdx < HD && pdy >= 0 && pdy < VD;
    e_rgb = !act ? 24'h0 : (on_box(pdx, pdy) ? COLOR : pix(pdx, pdy));
    #1;
    chk("hs", 32'(bus.lcd_hs), 32'(mh >= HS));
    chk("vs", 32'(bus.lcd_vs), 32'(mv >= VS));
    chk("en", 32'(bus.lcd_en), 32'(act));
    chk("rgb", 32'(bus.lcd_rgb), 32'(e_rgb));
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end
    cdx = mh - (HS + HB);
    cdy = mv - (VS + VB);
    r = cdx + AH;
    e_req = '0; e_x = '0; e_y = '0;
    if (cdy >= Y0 && cdy < Y0 + WH && r >= 0 && r < NW * WW) begin
      e_req = NW'(1) << (r / WW);
      e_x = 12'(r % WW);
      e_y = 12'(cdy - Y0);
    end
    chk("request", 32'(bus.lcd_request), 32'(e_req));
    chk("req_x", 32'(bus.lcd_req_x), 32'(e_x));
    chk("req_y", 32'(bus.lcd_req_y), 32'(e_y));
    chk("frame_start", 32'(bus.frame_start), 32'(mh == 0 && mv == 0));
    chk("onehot", 32'($countones(bus.lcd_request) <= 1), 32'd1);
  endtask

  task automatic set_box(input bit v, input int x0, input int x1, input int y0, input int y1);
    bus.box_valid = v;
    bus.box_x0 = 12'(x0); bus.box_x1 = 12'(x1);
    bus.box_y0 = 12'(y0); bus.box_y1 = 12'(y1);
  endtask

  int mid;

  initial begin
    set_box(1'b0, 0, 0, 0, 0);
    model_reset();
    repeat (6) @(posedge clk);
    #1;
    chk("rst_hs", 32'(bus.lcd_hs), 32'd0);
    chk("rst_vs", 32'(bus.lcd_vs), 32'd0);
    chk("rst_en", 32'(bus.lcd_en), 32'd0);
    chk("rst_rgb", 32'(bus.lcd_rgb), 32'd0);
    rst_n = 1'b1;
    repeat (300) step();

    // Asynchronous reset in the middle of a line
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_hs", 32'(bus.lcd_hs), 32'd0);
    chk("mid_rst_vs", 32'(bus.lcd_vs), 32'd0);
    chk("mid_rst_en", 32'(bus.lcd_en), 32'd0);
    chk("mid_rst_rgb", 32'(bus.lcd_rgb), 32'd0);
    repeat (AH + 2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    for (int f = 0; f < 10; f++) begin
      case (f)
        0: set_box(1'b0, 3, 10, 8, 14);
        1: set_box(1'b1, 3, 10, 8, 14);
        2: set_box(1'b1, 30, 20, 6, 20);
        3: set_box(1'b1, 0, 9, 0, 12);
        4: set_box(1'b1, 12, 12, 6, 20);
        5: set_box(1'b1, 33, 4095, 25, 4095);
        default: ;
      endcase
      mid = int'($urandom_range(100, FRAME - 100));
      repeat (mid) step();
      // Mid-frame change: must only take effect at the next frame start
      set_box(1'(($urandom_range(0, 3)) != 0), int'($urandom_range(0, 45)),
              int'($urandom_range(0, 45)), int'($urandom_range(0, 35)),
              int'($urandom_range(0, 35)));
      repeat (FRAME - mid) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
